shift_seq: RTL
==============

SHIFT_SEQ -- requirements
Module: SHIFT_SEQ

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous active-high reset.
REQ-004 Port: start  input  1  one-cycle request to begin a shift; sampled only in IDLE.
REQ-005 Port: op  input  2  0=SLL, 1=SRL, 2=SRA, 3=reserved (pass-through).
REQ-006 Port: shamt  input  5  requested shift amount, 0..31.
REQ-007 Port: operand  input  32  value to shift, latched with start.
REQ-008 Port: aluResult  input  32  combinational ALU output for the current aluA/ALUctrl.
REQ-009 Port: aluA  output  32  ALU operand, equal to internal accumulator.
REQ-010 Port: ALUctrl  output  6  ALU control code for the current step.
REQ-011 Port: busy  output  1  high in SHIFT and DONE.
REQ-012 Port: stall  output  1  pipeline hold request.
REQ-013 Port: done  output  1  one-cycle pulse; result valid.
REQ-014 Port: result  output  32  final shifted value, held until the next accepted start.

Function
REQ-015 States SHALL be IDLE, SHIFT, DONE.
REQ-016 IDLE + start: latch op, operand into accumulator, shamt into remaining; go to SHIFT if shamt!=0 and op!=3, else DONE.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 Step per SHIFT cycle SHALL be greedy: 8 if remaining>=8, else 2 if remaining>=2, else 1.
REQ-019 ALUctrl in SHIFT SHALL be SLL 1/2/8 = 0x0A/0x0B/0x0C, SRL = 0x0D/0x0E/0x0F, SRA = 0x10/0x11/0x12; ALUctrl=0x00 in IDLE and DONE.
REQ-020 Each SHIFT cycle, on the edge: accumulator <= aluResult, remaining <= remaining - step (5-bit, never below 0).
REQ-021 SHIFT -> DONE when the step executed equals remaining; otherwise stay in SHIFT.
REQ-022 Step count SHALL be (shamt>>3)+((shamt&7)>>1)+(shamt&1), max 7 (shamt=31).
REQ-023 Latency: start accepted at edge 0, done high in cycle k+1, where k=step count (k=0 for shamt=0 or op=3).
REQ-024 DONE: done=1, result <= accumulator (visible same cycle as done via bypass), then IDLE next edge.
REQ-025 stall SHALL be (state==IDLE and start) or state==SHIFT; stall=0 in DONE so the pipeline advances with result.
REQ-026 op=3 SHALL behave as shamt=0: result=operand, no nonzero ALUctrl issued.

Reset
REQ-027 On reset assertion, regardless of state, state SHALL become IDLE immediately (asynchronously).
REQ-028 Reset values: ALUctrl=0x00, aluA=0, result=0, busy=0, stall=0, done=0, remaining=0.
REQ-029 An operation interrupted by reset SHALL be abandoned; no done pulse after release.

Structure
REQ-030 A shared package/include SHALL hold op encodings, the nine shift ALUctrl codes, and state encodings; ALUCTRL decode and this block use the same codes.
REQ-031 One combinational sub-module SHIFT_STEP (inputs op, remaining; outputs step, ALUctrl code) SHALL implement REQ-018/REQ-019.
REQ-032 The ALU is not instantiated inside; aluA/ALUctrl/aluResult connect to the existing ALU.

Verification
REQ-033 SLL operand=0x00000001 shamt=13 -> ALUctrl 0x0C,0x0B,0x0B,0x0A in cycles 1-4; done cycle 5; result=0x00002000.
REQ-034 SRA operand=0x80000000 shamt=31 -> ALUctrl 0x12 x3, 0x11 x3, 0x10; done cycle 8; result=0xFFFFFFFF.
REQ-035 SRL operand=0xF0000000 shamt=4 -> ALUctrl 0x0E,0x0E; done cycle 3; result=0x0F000000; stall=1 cycles 0-2, 0 in cycle 3.
REQ-036 SRL operand=0x00001234 shamt=0, and op=3 shamt=9 -> done cycle 1, result=operand, ALUctrl stays 0x00.
REQ-037 Second start pulsed in cycle 2 of a shamt=13 op -> ignored; single done in cycle 5; result unchanged by second request.
REQ-038 reset asserted in cycle 2 of a shamt=31 op -> busy=stall=0 and result=0 immediately; no done after release; next start operates normally.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: op codes, FSM states
// and the nine shift ALU control codes also used by the ALU's control decode.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'd0,
        OP_SRL  = 2'd1,
        OP_SRA  = 2'd2,
        OP_PASS = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [5:0] ALU_NOP  = 6'h00;
    localparam logic [5:0] ALU_SLL1 = 6'h0A;
    localparam logic [5:0] ALU_SLL2 = 6'h0B;
    localparam logic [5:0] ALU_SLL8 = 6'h0C;
    localparam logic [5:0] ALU_SRL1 = 6'h0D;
    localparam logic [5:0] ALU_SRL2 = 6'h0E;
    localparam logic [5:0] ALU_SRL8 = 6'h0F;
    localparam logic [5:0] ALU_SRA1 = 6'h10;
    localparam logic [5:0] ALU_SRA2 = 6'h11;
    localparam logic [5:0] ALU_SRA8 = 6'h12;

    // size: 0 = shift by 1, 1 = by 2, 2 = by 8
    function automatic logic [5:0] shift_ctrl(input op_t op, input logic [1:0] size);
        logic [5:0] code;
        code = ALU_NOP;
        case (op)
            OP_SLL:  code = (size == 2'd2) ? ALU_SLL8 : (size == 2'd1) ? ALU_SLL2 : ALU_SLL1;
            OP_SRL:  code = (size == 2'd2) ? ALU_SRL8 : (size == 2'd1) ? ALU_SRL2 : ALU_SRL1;
            OP_SRA:  code = (size == 2'd2) ? ALU_SRA8 : (size == 2'd1) ? ALU_SRA2 : ALU_SRA1;
            default: code = ALU_NOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/shift_seq_step.sv
// Greedy step chooser: picks the largest ALU shift (8/2/1) that fits in the
// remaining amount and the matching ALU control code.
module shift_seq_step
    import shift_seq_pkg::*;
(
    input  op_t        op,
    input  logic [4:0] remaining,
    output logic [4:0] step,
    output logic [5:0] aluctrl
);

    logic [1:0] size;

    always_comb begin
        size = 2'd0;
        step = 5'd0;
        if (remaining >= 5'd8) begin
            size = 2'd2;
            step = 5'd8;
        end else if (remaining >= 5'd2) begin
            size = 2'd1;
            step = 5'd2;
        end else if (remaining != 5'd0) begin
            size = 2'd0;
            step = 5'd1;
        end
        aluctrl = shift_ctrl(op, size);
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter that drives an external ALU one shift step per cycle
// and holds the pipeline until the final value is ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; stall follows start combinationally
// ST_SHIFT | one ALU shift step per cycle, accumulator <= aluResult
// ST_DONE  | one-cycle done pulse, result bypassed from accumulator
module shift_seq
    import shift_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  shamt,
    input  logic [31:0] operand,
    input  logic [31:0] aluResult,
    output logic [31:0] aluA,
    output logic [5:0]  ALUctrl,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    state_t      state;
    op_t         op_q;
    logic [31:0] acc;
    logic [31:0] result_q;
    logic [4:0]  remaining;
    logic [4:0]  step;
    logic [5:0]  step_ctrl;

    shift_seq_step u_step (
        .op        (op_q),
        .remaining (remaining),
        .step      (step),
        .aluctrl   (step_ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_SLL;
            acc       <= 32'd0;
            remaining <= 5'd0;
            result_q  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= op_t'(op);
                        acc  <= operand;
                        // pass-through behaves exactly like a zero shift
                        if (shamt != 5'd0 && op_t'(op) != OP_PASS) begin
                            remaining <= shamt;
                            state     <= ST_SHIFT;
                        end else begin
                            remaining <= 5'd0;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc       <= aluResult;
                    remaining <= remaining - step;
                    if (step == remaining) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    result_q <= acc;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign aluA    = acc;
    assign ALUctrl = (state == ST_SHIFT) ? step_ctrl : ALU_NOP;
    assign busy    = (state == ST_SHIFT) || (state == ST_DONE);
    assign stall   = ((state == ST_IDLE) && start) || (state == ST_SHIFT);
    assign done    = (state == ST_DONE);
    assign result  = (state == ST_DONE) ? acc : result_q;

endmodule
